// File: rtl/block_copy_dma_pkg.sv
// Shared definitions for the page-copy DMA: state encoding and the typed FSM state.
package block_copy_dma_pkg;

  localparam logic [2:0] DMA_IDLE  = 3'd0;
  localparam logic [2:0] DMA_ALIGN = 3'd1;
  localparam logic [2:0] DMA_READ  = 3'd2;
  localparam logic [2:0] DMA_COPY  = 3'd3;
  localparam logic [2:0] DMA_LAST  = 3'd4;
  localparam logic [2:0] DMA_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = DMA_IDLE,
    S_ALIGN = DMA_ALIGN,
    S_READ  = DMA_READ,
    S_COPY  = DMA_COPY,
    S_LAST  = DMA_LAST,
    S_DONE  = DMA_DONE
  } dma_state_e;

endpackage

// File: rtl/block_copy_dma.sv
// Copies one 2**LEN_WIDTH-word page from a 1-cycle-latency source RAM into a destination RAM,
// one word per cycle, with pause support and a busy flag for CPU stalling.
module block_copy_dma
  import block_copy_dma_pkg::*;
#(
  parameter int SRC_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 8,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [SRC_ADDR_WIDTH-LEN_WIDTH-1:0] src_page,
  input  logic                                odd_cycle,
  input  logic                                pause,
  output logic [SRC_ADDR_WIDTH-1:0]           src_addr,
  input  logic [DATA_WIDTH-1:0]               src_din,
  output logic [LEN_WIDTH-1:0]                dst_addr,
  output logic                                dst_we,
  output logic [DATA_WIDTH-1:0]               dst_dout,
  output logic                                busy,
  output logic                                done
);

  localparam int PAGE_W = SRC_ADDR_WIDTH - LEN_WIDTH;

  localparam logic [LEN_WIDTH:0]   IDX_ONE   = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0]   IDX_FINAL = {1'b0, {LEN_WIDTH{1'b1}}};
  localparam logic [LEN_WIDTH-1:0] LO_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  dma_state_e          state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [LEN_WIDTH:0]  idx_q, idx_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [LEN_WIDTH-1:0] idx_lo;
  logic [LEN_WIDTH-1:0] prev_lo;
  logic [LEN_WIDTH-1:0] rd_lo;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          page_d  = src_page;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = odd_cycle ? S_ALIGN : S_READ;
        end
      end
      S_ALIGN: begin
        if (!pause) state_d = S_READ;
      end
      S_READ: begin
        if (!pause) begin
          idx_d   = IDX_ONE;
          we_d    = 1'b1;
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        if (!pause) begin
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_FINAL) state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (!pause) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // While a write is pending (paused COPY, or LAST) keep re-reading the word being written,
  // so src_din still carries it when the write finally happens.
  always_comb begin
    idx_lo  = idx_q[LEN_WIDTH-1:0];
    prev_lo = idx_lo - LO_ONE;
    rd_lo   = idx_lo;
    if (state_q == S_LAST || (state_q == S_COPY && pause)) rd_lo = prev_lo;
  end

  assign src_addr = {page_q, rd_lo};
  assign dst_addr = we_q ? prev_lo : '0;
  assign dst_we   = we_q & ~pause;
  assign dst_dout = src_din;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_block_copy_dma.sv
// Bench for block_copy_dma: synchronous-read source RAM and destination RAM models, directed and
// randomized page copies checked against a page-copy reference with latency computed from the rules.
module tb_block_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  src_page;
  logic        odd_cycle;
  logic        pause;
  logic [15:0] src_addr;
  logic [7:0]  src_din;
  logic [7:0]  dst_addr;
  logic        dst_we;
  logic [7:0]  dst_dout;
  logic        busy;
  logic        done;

  logic [7:0] src_mem [0:65535];
  logic [7:0] dst_mem [0:255];

  int errors = 0;
  int checks = 0;

  block_copy_dma #(.SRC_ADDR_WIDTH(16), .LEN_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_page(src_page), .odd_cycle(odd_cycle),
    .pause(pause), .src_addr(src_addr), .src_din(src_din), .dst_addr(dst_addr),
    .dst_we(dst_we), .dst_dout(dst_dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_din <= src_mem[src_addr];
  always @(posedge clk) if (dst_we) dst_mem[dst_addr] <= dst_dout;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_page(input logic [7:0] page, input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0] ^ 8'h5A;
      if (rnd) v = 8'($urandom);
      src_mem[{page, i[7:0]}] = v;
    end
  endtask

  // One transfer: reference latency = 258 + odd + pause length, 256 ascending writes of the page.
  task automatic run_xfer(input string name, input logic [7:0] page, input bit odd, input int p0,
                          input int plen, input bit spam, input int abort_n);
    int done_n, first_we, nwr, ord_err, data_err, wp_err, pg_err, done_cnt, exp_done, exp_first;
    int mem_err;
    logic [7:0] next_a;
    exp_done  = 258 + int'(odd) + plen;
    exp_first = 2 + int'(odd) + ((plen > 0 && p0 <= 2 + int'(odd)) ? plen : 0);
    done_n = -1; first_we = -1; nwr = 0; ord_err = 0; data_err = 0; wp_err = 0;
    pg_err = 0; done_cnt = 0; next_a = 8'h00;
    @(negedge clk);
    src_page = page; odd_cycle = odd; start = 1'b1; pause = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      src_page  = 8'($urandom);
      odd_cycle = 1'($urandom);
      start = 1'b0;
      if (spam && n <= exp_done) start = (n == exp_done) ? 1'b1 : 1'($urandom);
      pause = (n >= p0 && n < p0 + plen);
      if (n == abort_n) rst_n = 1'b0;
      #1;
      if (n == abort_n) begin
        check_eq({name, "_rst_busy"}, busy, 1'b0);
        check_eq({name, "_rst_we"}, dst_we, 1'b0);
      end
      if (n == 1 + int'(odd) && p0 > 2 + int'(odd)) begin
        check_eq({name, "_first_rd"}, src_addr, {page, 8'h00});
        check_eq({name, "_busy_early"}, busy, 1'b1);
      end
      if (dst_we) begin
        nwr++;
        if (first_we < 0) first_we = n;
        if (dst_addr !== next_a) ord_err++;
        if (dst_dout !== src_mem[{page, dst_addr}]) data_err++;
        next_a++;
      end
      if (pause && dst_we) wp_err++;
      if (busy && src_addr[15:8] !== page) pg_err++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
        check_eq({name, "_busy_at_done"}, busy, 1'b0);
      end
      if (abort_n == 0 && done_n > 0 && n >= done_n + 3) break;
      if (abort_n > 0 && n >= abort_n + 4) break;
    end
    pause = 1'b0; start = 1'b0;
    if (abort_n > 0) begin
      check_eq({name, "_no_done"}, done_cnt, 0);
      check_eq({name, "_partial_wr"}, nwr, abort_n - 2);
      check_eq({name, "_busy_held"}, busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    mem_err = 0;
    for (int i = 0; i < 256; i++)
      if (dst_mem[i] !== src_mem[{page, i[7:0]}]) mem_err++;
    check_eq({name, "_done_cyc"}, done_n, exp_done);
    check_eq({name, "_done_cnt"}, done_cnt, 1);
    check_eq({name, "_nwrites"}, nwr, 256);
    check_eq({name, "_order"}, ord_err, 0);
    check_eq({name, "_wdata"}, data_err, 0);
    check_eq({name, "_we_in_pause"}, wp_err, 0);
    check_eq({name, "_page"}, pg_err, 0);
    check_eq({name, "_first_we"}, first_we, exp_first);
    check_eq({name, "_dst_mem"}, mem_err, 0);
    check_eq({name, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_page = 8'h00; odd_cycle = 1'b0; pause = 1'b0;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    #1;
    check_eq("rst_src_addr", src_addr, 16'h0000);
    check_eq("rst_dst_addr", dst_addr, 8'h00);
    check_eq("rst_dst_we", dst_we, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_page(8'h02, 1'b0);
    run_xfer("t1_even", 8'h02, 1'b0, 1000, 0, 1'b0, 0);
    fill_page(8'h02, 1'b1);
    run_xfer("t2_odd", 8'h02, 1'b1, 1000, 0, 1'b0, 0);
    fill_page(8'h04, 1'b1);
    run_xfer("t3_pause", 8'h04, 1'b0, 129, 5, 1'b0, 0);
    check_eq("t3_dst7f", dst_mem[8'h7F], src_mem[16'h047F]);
    check_eq("t3_dst80", dst_mem[8'h80], src_mem[16'h0480]);
    fill_page(8'h05, 1'b1);
    run_xfer("t4_spam", 8'h05, 1'b0, 1000, 0, 1'b1, 0);
    repeat (3) @(negedge clk);
    check_eq("t4_no_restart", busy, 1'b0);
    fill_page(8'h06, 1'b1);
    run_xfer("t5_abort", 8'h06, 1'b0, 1000, 0, 1'b0, 65);
    fill_page(8'h03, 1'b1);
    run_xfer("t5_after", 8'h03, 1'b0, 1000, 0, 1'b0, 0);
    fill_page(8'hFF, 1'b1);
    run_xfer("t6_top", 8'hFF, 1'b0, 1000, 0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] pg;
      pg = 8'($urandom);
      fill_page(pg, 1'b1);
      run_xfer($sformatf("r%0d", k), pg, 1'($urandom), int'($urandom_range(1, 250)),
               int'($urandom_range(0, 6)), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
